// File: rtl/raycast_pkg.sv
// raycast_pkg: shared column record type, beat packing helpers and encoder constants
// Contents: column_t record layout, COL_W, NUM_COLS_DEFAULT, encoder FSM states,
//           pack_hi()/pack_lo() beat builders.
package raycast_pkg;
    localparam int COL_W = 29;
    localparam int NUM_COLS_DEFAULT = 640;
    typedef struct packed {
        logic       sf_sel;
        logic [8:0] top;
        logic       dir;
        logic [2:0] tex;
        logic [8:0] h_sf;
        logic [5:0] off;
    } column_t;
    typedef enum logic [2:0] {IDLE, BEAT0, GAP0, BEAT1, GAP1} enc_state_t;
    function automatic logic [15:0] pack_hi(input column_t c);
        return {2'b00, c.sf_sel, c.top, c.dir, c.tex};
    endfunction
    function automatic logic [15:0] pack_lo(input column_t c);
        return {1'b0, c.h_sf, c.off};
    endfunction
endpackage

// File: rtl/col_fifo.sv
// col_fifo: synchronous FIFO for column records
// Ports: clk, reset (sync, active-high); push/wr_data write side (ignored when full);
//        pop/rd_data read side (rd_data shows the head entry, ignored when empty);
//        full, empty, count derived from a registered occupancy count.
module col_fifo #(
    parameter int WIDTH = 29,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop) count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/column_encoder.sv
// column_encoder: buffers column records and serialises each into two Avalon-MM write beats
// Ports: clk, reset (sync, active-high);
//        in_valid/in_ready/in_col_data  record input (in_ready = FIFO not full);
//        avm_chipselect/avm_write/avm_writedata/avm_waitrequest  Avalon-MM master;
//        col_count  index of next column to send; frame_done  pulse after last column;
//        busy  FSM active or records buffered.
module column_encoder
    import raycast_pkg::*;
#(
    parameter int NUM_COLS   = NUM_COLS_DEFAULT,
    parameter int FIFO_DEPTH = 8,
    parameter int GAP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [COL_W-1:0] in_col_data,
    output logic             avm_chipselect,
    output logic             avm_write,
    output logic [15:0]      avm_writedata,
    input  logic             avm_waitrequest,
    output logic [9:0]       col_count,
    output logic             frame_done,
    output logic             busy
);
    localparam bit HAS_GAP = GAP_CYCLES > 0;
    localparam logic [3:0] GAP_LAST = HAS_GAP ? 4'(GAP_CYCLES - 1) : 4'd0;
    enc_state_t state;
    column_t hold;
    logic [3:0] gap_cnt;
    logic [COL_W-1:0] fifo_rd;
    logic fifo_full, fifo_empty, fifo_pop, accept, last_col;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    col_fifo #(.WIDTH(COL_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (in_valid),
        .wr_data (in_col_data),
        .pop     (fifo_pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign in_ready       = !fifo_full;
    assign accept         = !avm_waitrequest;
    assign last_col       = col_count == 10'(NUM_COLS - 1);
    assign avm_write      = state == BEAT0 || state == BEAT1;
    assign avm_chipselect = avm_write;
    assign avm_writedata  = state == BEAT0 ? pack_hi(hold) : state == BEAT1 ? pack_lo(hold) : 16'h0000;
    assign busy           = state != IDLE || fifo_count != '0;
    // A new pair may start from IDLE, or straight out of the final cycle of a pair
    // (BEAT1 accept without gaps, or the last GAP1 cycle) so pairs run back-to-back.
    assign fifo_pop = !fifo_empty && (state == IDLE ||
                      (state == BEAT1 && accept && !HAS_GAP) ||
                      (state == GAP1 && gap_cnt == 4'd0));

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            hold       <= '0;
            gap_cnt    <= '0;
            col_count  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (fifo_pop) hold <= fifo_rd;
            case (state)
                IDLE: if (fifo_pop) state <= BEAT0;
                BEAT0: if (accept) begin
                    state   <= HAS_GAP ? GAP0 : BEAT1;
                    gap_cnt <= GAP_LAST;
                end
                GAP0: if (gap_cnt == 4'd0) state <= BEAT1;
                      else gap_cnt <= gap_cnt - 1'b1;
                BEAT1: if (accept) begin
                    col_count  <= last_col ? '0 : col_count + 1'b1;
                    frame_done <= last_col;
                    gap_cnt    <= GAP_LAST;
                    state      <= HAS_GAP ? GAP1 : fifo_pop ? BEAT0 : IDLE;
                end
                GAP1: if (gap_cnt == 4'd0) state <= fifo_pop ? BEAT0 : IDLE;
                      else gap_cnt <= gap_cnt - 1'b1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_column_encoder.sv
// tb_column_encoder: scoreboard bench for column_encoder (GAP=0 instance and GAP=2 instance)
module tb_column_encoder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in_valid = 1'b0;
    logic [28:0] in_col_data = '0;
    logic avm_waitrequest = 1'b0;
    logic in_ready, avm_chipselect, avm_write, frame_done, busy;
    logic [15:0] avm_writedata;
    logic [9:0] col_count;
    logic b_valid = 1'b0;
    logic [28:0] b_data = '0;
    logic b_wait = 1'b0;
    logic b_ready, b_cs, b_write, b_fd, b_busy;
    logic [15:0] b_wd;
    logic [9:0] b_count;

    column_encoder dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_col_data(in_col_data), .avm_chipselect(avm_chipselect), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
        .col_count(col_count), .frame_done(frame_done), .busy(busy)
    );

    column_encoder #(.GAP_CYCLES(2)) dut_gap (
        .clk(clk), .reset(reset), .in_valid(b_valid), .in_ready(b_ready),
        .in_col_data(b_data), .avm_chipselect(b_cs), .avm_write(b_write),
        .avm_writedata(b_wd), .avm_waitrequest(b_wait),
        .col_count(b_count), .frame_done(b_fd), .busy(b_busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0, cyc = 0, fd_cnt = 0, fd_cyc = 0;
    logic [15:0] exp_q[$], expb_q[$];
    int beat_cyc_q[$], b_cyc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] hi(input logic [28:0] d);
        return {2'b00, d[28:15]};
    endfunction
    function automatic logic [15:0] lo(input logic [28:0] d);
        return {1'b0, d[14:0]};
    endfunction
    function automatic logic [28:0] pat(input int i);
        logic [28:0] x;
        x = 29'(i) * 29'h0123_4567;
        return x ^ 29'h1555_AAAA;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Must be called just after a rising edge; returns just after the accepting edge.
    task automatic push(input logic [28:0] d);
        bit ok = 0;
        in_valid = 1'b1;
        in_col_data = d;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) ok = 1;
            else step();
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL push_timeout: in_ready stayed 0 for record %h", d);
        end else begin
            exp_q.push_back(hi(d));
            exp_q.push_back(lo(d));
        end
        step();
        in_valid = 1'b0;
    endtask

    always @(negedge clk) if (!reset) begin
        chk("cs_eq_write", avm_chipselect, avm_write);
        if (!avm_write) chk("idle_data", avm_writedata, 0);
        if (avm_write && !avm_waitrequest) begin
            beat_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_beat: data %h with nothing expected", avm_writedata);
            end else chk("beat_data", avm_writedata, exp_q.pop_front());
        end
        if (frame_done) begin
            fd_cnt <= fd_cnt + 1;
            fd_cyc <= cyc;
        end
        if (!b_write) chk("gap_idle_data", b_wd, 0);
        if (b_write) begin
            b_cyc_q.push_back(cyc);
            if (expb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL gap_unexpected_beat: data %h with nothing expected", b_wd);
            end else chk("gap_beat_data", b_wd, expb_q.pop_front());
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int idx, f0, acc;
        repeat (3) step();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_write", avm_write, 0);
        chk("rst_cs", avm_chipselect, 0);
        chk("rst_data", avm_writedata, 0);
        chk("rst_col_count", col_count, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_busy", busy, 0);

        // single record latency and packing
        step();
        push(29'h1ABC_DEF1);
        @(negedge clk);
        chk("t1_no_write_t1", avm_write, 0);
        @(negedge clk);
        chk("t1_beat0_write", avm_write, 1);
        chk("t1_beat0_data", avm_writedata, 16'h3579);
        @(negedge clk);
        chk("t1_beat1_write", avm_write, 1);
        chk("t1_beat1_data", avm_writedata, 16'h5EF1);
        chk("t1_count_before", col_count, 0);
        @(negedge clk);
        chk("t1_count_after", col_count, 1);
        chk("t1_frame_done", frame_done, 0);
        chk("t1_write_done", avm_write, 0);

        // full frame back-to-back
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        idx = beat_cyc_q.size();
        f0 = fd_cnt;
        for (int i = 0; i < 640; i++) push(pat(i + 100));
        for (int k = 0; k < 3000 && beat_cyc_q.size() < idx + 1280; k++) step();
        chk("t2_beat_total", beat_cyc_q.size() - idx, 1280);
        if (beat_cyc_q.size() >= idx + 1280)
            chk("t2_beat_span", beat_cyc_q[idx+1279] - beat_cyc_q[idx], 1279);
        repeat (3) step();
        chk("t2_frame_done_cnt", fd_cnt - f0, 1);
        if (beat_cyc_q.size() >= idx + 1280)
            chk("t2_frame_done_cyc", fd_cyc, beat_cyc_q[idx+1279] + 1);
        chk("t2_col_count_wrap", col_count, 0);

        // stall during beat1
        idx = beat_cyc_q.size();
        push(pat(7));
        step();
        step();
        avm_waitrequest = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_stall_write", avm_write, 1);
            chk("t3_stall_data", avm_writedata, lo(pat(7)));
            chk("t3_stall_count", col_count, 0);
            step();
        end
        avm_waitrequest = 1'b0;
        step();
        @(negedge clk);
        chk("t3_count_once", col_count, 1);
        chk("t3_beats", beat_cyc_q.size() - idx, 2);

        // FIFO fill with sink stalled
        step();
        avm_waitrequest = 1'b1;
        acc = 0;
        in_valid = 1'b1;
        in_col_data = pat(200);
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (in_ready && acc < 10) begin
                exp_q.push_back(hi(pat(200 + acc)));
                exp_q.push_back(lo(pat(200 + acc)));
                acc++;
            end
            step();
            in_col_data = pat(200 + acc);
        end
        @(negedge clk);
        chk("t4_accepted", acc, 9);
        chk("t4_in_ready_low", in_ready, 0);
        step();
        avm_waitrequest = 1'b0;
        push(pat(209));
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) step();
        chk("t4_drained", exp_q.size(), 0);

        // reset between beat0 and beat1
        push(pat(300));
        push(pat(301));
        step();
        reset = 1'b1;
        exp_q.delete();
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("t5_write", avm_write, 0);
        chk("t5_col_count", col_count, 0);
        chk("t5_busy", busy, 0);
        chk("t5_in_ready", in_ready, 1);
        step();
        idx = beat_cyc_q.size();
        push(pat(302));
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) step();
        chk("t5_restart_beats", beat_cyc_q.size() - idx, 2);
        chk("t5_count_after", col_count, 1);

        // gap instance spacing
        idx = b_cyc_q.size();
        for (int i = 0; i < 3; i++) begin
            b_data = pat(400 + i);
            b_valid = 1'b1;
            @(negedge clk);
            chk("t6_in_ready", b_ready, 1);
            expb_q.push_back(hi(pat(400 + i)));
            expb_q.push_back(lo(pat(400 + i)));
            step();
        end
        b_valid = 1'b0;
        for (int k = 0; k < 100 && b_cyc_q.size() < idx + 6; k++) step();
        chk("t6_beats", b_cyc_q.size() - idx, 6);
        if (b_cyc_q.size() >= idx + 6)
            for (int i = 1; i < 6; i++)
                chk("t6_spacing", b_cyc_q[idx+i] - b_cyc_q[idx+i-1], 3);
        repeat (4) step();
        @(negedge clk);
        chk("t6_count", b_count, 3);
        chk("t6_busy", b_busy, 0);
        chk("t6_frame_done", b_fd, 0);
        chk("end_busy", busy, 0);

        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
